// File: rtl/loop_nest_scheduler_pkg.sv
// Shared types for the two-level loop nest scheduler.
// Optional build macro LOOP_SCHED_PERF_EN adds a stall-cycle counter to the top.
package loop_sched_pkg;
    localparam int DEFAULT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;
endpackage

// File: rtl/loop_nest_scheduler_if.sv
// Control/status bundle between the loop nest scheduler (slave) and its user (master).
// stall_cycles exists only when LOOP_SCHED_PERF_EN is defined.
interface loop_nest_scheduler_if #(
    parameter int W = loop_sched_pkg::DEFAULT_W
) ();
    logic         start;
    logic         stall;
    logic         busy;
    logic         iter_valid;
    logic [W-1:0] outer_idx;
    logic [W-1:0] inner_idx;
    logic         last_iter;
    logic         done;
`ifdef LOOP_SCHED_PERF_EN
    logic [W-1:0] stall_cycles;
`endif

    modport master (
        output start, stall,
`ifdef LOOP_SCHED_PERF_EN
        input  stall_cycles,
`endif
        input  busy, iter_valid, outer_idx, inner_idx, last_iter, done
    );

    modport slave (
        input  start, stall,
`ifdef LOOP_SCHED_PERF_EN
        output stall_cycles,
`endif
        output busy, iter_valid, outer_idx, inner_idx, last_iter, done
    );
endinterface

// File: rtl/loop_nest_scheduler_ii_pacer.sv
// Initiation-interval pacer: fires on unstalled cycles where the pace count is 0.
// The count advances only on unstalled cycles and is held at 0 while clear is high.
module ii_pacer #(
    parameter int II = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    output logic fire
);
    localparam int PW = (II > 1) ? $clog2(II) : 1;
    localparam logic [PW-1:0] PACE_LAST = PW'(II - 1);

    logic [PW-1:0] pace;

    always_ff @(posedge clk) begin
        if (rst || clear)
            pace <= '0;
        else if (!stall)
            pace <= (pace == PACE_LAST) ? '0 : pace + 1'b1;
    end

    assign fire = (pace == '0) && !stall;
endmodule

// File: rtl/loop_nest_scheduler.sv
// Issues a row-major two-level loop nest at one iteration per II unstalled cycles,
// drains DEPTH cycles, then pulses done. Optional: LOOP_SCHED_PERF_EN (stall_cycles).
module loop_nest_scheduler
    import loop_sched_pkg::*;
#(
    parameter int N_OUTER = 4,
    parameter int N_INNER = 4,
    parameter int II      = 1,
    parameter int DEPTH   = 3,
    parameter int W       = DEFAULT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    loop_nest_scheduler_if.slave  bus
);
    if (N_OUTER < 1 || N_INNER < 1 || II < 1) begin : g_bad_params
        $error("loop_nest_scheduler: N_OUTER, N_INNER and II must all be >= 1");
    end

    localparam logic [W-1:0] OUTER_LAST = W'(N_OUTER - 1);
    localparam logic [W-1:0] INNER_LAST = W'(N_INNER - 1);
    localparam logic [W-1:0] DRAIN_LOAD = W'(DEPTH);

    sched_state_e state_q, state_d;
    logic [W-1:0] outer_q, outer_d;
    logic [W-1:0] inner_q, inner_d;
    logic [W-1:0] drain_q, drain_d;
    logic         fire;
    logic         iter_valid;
    logic         last_iter;

    // Pace is pinned to 0 outside ISSUE so each nest starts with an immediate issue.
    ii_pacer #(.II(II)) u_pacer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q != ISSUE),
        .stall (bus.stall),
        .fire  (fire)
    );

    assign iter_valid = (state_q == ISSUE) && fire;
    assign last_iter  = iter_valid && (outer_q == OUTER_LAST) && (inner_q == INNER_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            outer_q <= '0;
            inner_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            outer_q <= outer_d;
            inner_q <= inner_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        outer_d = outer_q;
        inner_d = inner_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    outer_d = '0;
                    inner_d = '0;
                end
            end
            ISSUE: begin
                if (last_iter) begin
                    state_d = (DEPTH == 0) ? DONE : DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (iter_valid) begin
                    if (inner_q == INNER_LAST) begin
                        inner_d = '0;
                        outer_d = outer_q + W'(1);
                    end else begin
                        inner_d = inner_q + W'(1);
                    end
                end
            end
            DRAIN: begin
                if (!bus.stall) begin
                    drain_d = drain_q - W'(1);
                    if (drain_q == W'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                outer_d = '0;
                inner_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.iter_valid = iter_valid;
    assign bus.last_iter  = last_iter;
    assign bus.done       = (state_q == DONE);
    assign bus.outer_idx  = outer_q;
    assign bus.inner_idx  = inner_q;

`ifdef LOOP_SCHED_PERF_EN
    logic [W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (state_q == IDLE && bus.start)
            stall_cnt <= '0;
        else if ((state_q == ISSUE || state_q == DRAIN) && bus.stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + W'(1);
    end

    assign bus.stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_loop_nest_scheduler.sv
// Two scheduler configurations driven by one stimulus stream, checked cycle by cycle
// against a schedule planned from issue/drain counting rules.
module tb_loop_nest_scheduler;
    localparam int NC = 400;
    localparam int W  = 32;

    logic clk = 1'b0;
    logic rst;
    logic start_r, stall_r;
    always #5 clk = ~clk;

    loop_nest_scheduler_if #(.W(W)) bus_a ();
    loop_nest_scheduler_if #(.W(W)) bus_b ();

    assign bus_a.start = start_r;
    assign bus_a.stall = stall_r;
    assign bus_b.start = start_r;
    assign bus_b.stall = stall_r;

    loop_nest_scheduler #(.N_OUTER(2), .N_INNER(3), .II(1), .DEPTH(2), .W(W)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    loop_nest_scheduler #(.N_OUTER(1), .N_INNER(2), .II(3), .DEPTH(0), .W(W)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    typedef struct {
        bit busy;
        bit iv;
        bit last;
        bit done;
        int oi;
        int ii;
    } exp_t;

    bit   st_start [NC];
    bit   st_stall [NC];
    bit   st_rst   [NC];
    exp_t ex [2][NC];
    int   vectors = 0;
    int   errs    = 0;

    // Expected output per cycle: an accepted start at s issues iteration k on the
    // unstalled ISSUE cycle whose count of prior unstalled ISSUE cycles is a multiple
    // of II, then needs dep unstalled drain cycles and one done cycle.
    task automatic plan(input int inst, input int no, input int ni, input int ii, input int dep);
        int c, t, k, u, rem, nt;
        bit ab;
        for (int i = 0; i < NC; i++) ex[inst][i] = '{default: 0};
        nt = no * ni;
        c = 0;
        while (c < NC) begin
            if (st_start[c] && !st_rst[c]) begin
                t = c + 1; k = 0; u = 0; ab = 0;
                while (k < nt && !ab) begin
                    if (t >= NC || st_rst[t-1]) ab = 1;
                    else begin
                        ex[inst][t].busy = 1;
                        ex[inst][t].oi = k / ni;
                        ex[inst][t].ii = k % ni;
                        if (!st_stall[t]) begin
                            if (u % ii == 0) begin
                                ex[inst][t].iv = 1;
                                ex[inst][t].last = (k == nt - 1);
                                k++;
                            end
                            u++;
                        end
                        t++;
                    end
                end
                rem = dep;
                while (rem > 0 && !ab) begin
                    if (t >= NC || st_rst[t-1]) ab = 1;
                    else begin
                        ex[inst][t].busy = 1;
                        ex[inst][t].oi = no - 1;
                        ex[inst][t].ii = ni - 1;
                        if (!st_stall[t]) rem--;
                        t++;
                    end
                end
                if (!ab && t < NC && !st_rst[t-1]) begin
                    ex[inst][t].busy = 1;
                    ex[inst][t].done = 1;
                    ex[inst][t].oi = no - 1;
                    ex[inst][t].ii = ni - 1;
                    t++;
                end
                c = t;
            end else begin
                c++;
            end
        end
    endtask

    task automatic chk(input string tag, input int cyc, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            errs++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    initial begin
        // Directed regions first, random traffic afterwards.
        for (int c = 0; c < NC; c++) begin
            st_start[c] = 0; st_stall[c] = 0; st_rst[c] = 0;
        end
        st_start[0] = 1;
        st_start[30] = 1;
        for (int c = 30; c < 60; c++) st_stall[c] = ($urandom_range(0, 9) < 3);
        for (int c = 60; c < 100; c++) st_start[c] = 1;
        st_start[100] = 1;
        st_rst[103]   = 1;
        st_start[105] = 1;
        for (int c = 130; c < NC; c++) begin
            st_start[c] = ($urandom_range(0, 9) < 2);
            st_stall[c] = ($urandom_range(0, 3) == 0);
            st_rst[c]   = ($urandom_range(0, 99) == 0);
        end
        plan(0, 2, 3, 1, 2);
        plan(1, 1, 2, 3, 0);

        rst = 1'b1; start_r = 1'b0; stall_r = 1'b0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            rst     = st_rst[c];
            start_r = st_start[c];
            stall_r = st_stall[c];
            #1;
            chk("a_busy",  c, W'(bus_a.busy),       W'(ex[0][c].busy));
            chk("a_valid", c, W'(bus_a.iter_valid), W'(ex[0][c].iv));
            chk("a_last",  c, W'(bus_a.last_iter),  W'(ex[0][c].last));
            chk("a_done",  c, W'(bus_a.done),       W'(ex[0][c].done));
            chk("a_outer", c, bus_a.outer_idx,      W'(ex[0][c].oi));
            chk("a_inner", c, bus_a.inner_idx,      W'(ex[0][c].ii));
            chk("b_busy",  c, W'(bus_b.busy),       W'(ex[1][c].busy));
            chk("b_valid", c, W'(bus_b.iter_valid), W'(ex[1][c].iv));
            chk("b_last",  c, W'(bus_b.last_iter),  W'(ex[1][c].last));
            chk("b_done",  c, W'(bus_b.done),       W'(ex[1][c].done));
            chk("b_outer", c, bus_b.outer_idx,      W'(ex[1][c].oi));
            chk("b_inner", c, bus_b.inner_idx,      W'(ex[1][c].ii));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/loop_nest_scheduler.md
Name: loop_nest_scheduler

Overview:
- Sequences a two-level pipelined loop nest. On start, it issues one iteration every II unstalled cycles, walking outer and inner indices in row-major order.
- After the last issue it drains the pipeline for DEPTH cycles, then pulses done.
- Sits above the datapath counters and per-stage enable logic: its iter_valid, indices and last_iter drive the pipelined loop body.

Parameters:
- N_OUTER, 4, outer trip count (>=1).
- N_INNER, 4, inner trip count (>=1).
- II, 1, initiation interval in unstalled cycles (>=1).
- DEPTH, 3, pipeline drain cycles after the last issue (>=0).
- W, 32, index and counter width; N_OUTER-1 and N_INNER-1 must fit in W bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a loop nest; sampled only in IDLE.
- stall  in  1  datapath back-pressure; freezes issue pacing and drain.
- busy  out  1  high from the cycle after start is accepted through the done cycle inclusive.
- iter_valid  out  1  iteration issued this cycle.
- outer_idx  out  W  outer index of the current or next issue.
- inner_idx  out  W  inner index of the current or next issue.
- last_iter  out  1  iter_valid for index (N_OUTER-1, N_INNER-1).
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset: state IDLE; pace, drain and indices 0; all outputs 0. Reset mid-operation returns to IDLE at the next edge with no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE (encoded per package enum).
- IDLE:
  - start=1 -> ISSUE at the next edge; indices and pace cleared.
  - start in any other state (including DONE) is ignored.
  - Earliest restart is the cycle after done.
- ISSUE, pacing:
  - pace counter runs 0..II-1.
  - iter_valid = (pace==0) & !stall, combinational from registered state.
  - When !stall: pace wraps II-1 -> 0, otherwise increments. When stall: pace holds.
  - With II=1, an iteration issues on every unstalled cycle.
  - First iter_valid is possible 1 cycle after start is accepted.
- ISSUE, indexing on each iter_valid:
  - inner_idx increments.
  - At N_INNER-1, inner_idx wraps to 0 and outer_idx increments.
  - On last_iter, indices hold at (N_OUTER-1, N_INNER-1) and state -> DRAIN, or -> DONE if DEPTH==0.
- DRAIN:
  - drain counter loads DEPTH on entry and decrements on each unstalled cycle.
  - State -> DONE on the edge where the counter reaches 0 after its final decrement.
  - Unstalled, DRAIN occupies exactly DEPTH cycles: L+1..L+DEPTH, where L is the last-issue cycle.
- DONE: done=1 and busy=1 for one cycle, stall ignored; then -> IDLE, indices cleared.
- Latency, no stall: L = 1 + (N_OUTER*N_INNER-1)*II relative to the start cycle; done at L+DEPTH+1.
- Arithmetic: all counters unsigned W bits; index comparisons against N-1 only, never overflow.
- Parameter checks: N_OUTER, N_INNER or II < 1 -> elaboration-time error.

Optional Feature:
- Macro LOOP_SCHED_PERF_EN.
- Defined:
  - Adds output stall_cycles (W bits).
  - Counts cycles in ISSUE or DRAIN with stall=1.
  - Cleared when start is accepted; saturates at all-ones; holds value in IDLE; reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package loop_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE) and a default index width constant.
- Sub-module ii_pacer:
  - Inputs: clk, rst, clear, stall.
  - Output: fire, equal to (pace==0) & !stall.
  - Parameter: II.
  - Instantiated once for the ISSUE pacing.

Test Plan:
- N_OUTER=2, N_INNER=3, II=1, DEPTH=2; start at cycle 0 -> iter_valid cycles 1-6 with indices (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); last_iter at 6; done at 9; busy cycles 1-9.
- N_OUTER=1, N_INNER=2, II=3, DEPTH=0; start at cycle 0 -> iter_valid at cycles 1 and 4 only; done at 5.
- N_OUTER=1, N_INNER=3, II=1, DEPTH=1; stall=1 at cycles 2 and 5 -> iter_valid at 1, 3, 4; DRAIN at 5 (stalled) and 6; done at 7.
- Reset at cycle 3 of the first scenario -> cycle 4 all outputs 0, no done; fresh start at 5 -> first iter_valid at 6 with (0,0).
- start held high through the whole first scenario -> one sequence only; start at the done cycle ignored; start at cycle 10 begins a new sequence.
- LOOP_SCHED_PERF_EN, third scenario -> stall_cycles=2 after done; cleared to 0 on the next accepted start.
